// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared parameter defaults and legal ranges for the debounce bank
package debounce_pkg;

    localparam int NCH_DEFAULT           = 2;
    localparam int NCH_MIN               = 1;
    localparam int NCH_MAX               = 16;

    localparam int STABLE_CYCLES_DEFAULT = 1000000;
    localparam int STABLE_CYCLES_MIN     = 1;

    localparam int HOLD_CYCLES_DEFAULT   = 50000000;
    localparam int HOLD_CYCLES_MIN       = 1;

    localparam int SYNC_STAGES_DEFAULT   = 2;
    localparam int SYNC_STAGES_MIN       = 2;
    localparam int SYNC_STAGES_MAX       = 3;

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button channel: synchroniser, stable filter, edge pulses, long-press flag
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_hold
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [SW-1:0]          stable_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   flip;

    assign sync = sync_q[SYNC_STAGES-1];
    // The sample that would bring the stable count to STABLE_CYCLES flips the level instead.
    assign flip = (sync != btn_level) && (stable_cnt == STABLE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            btn_level  <= 1'b0;
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            btn_hold   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_in};
            btn_rise <= flip && !btn_level;
            btn_fall <= flip && btn_level;

            if ((sync == btn_level) || flip) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end

            if (flip) begin
                btn_level <= ~btn_level;
            end

            // Falling flip drops the hold flag on the same edge as the fall pulse.
            if (!btn_level || flip) begin
                hold_cnt <= '0;
                btn_hold <= 1'b0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    btn_hold <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of NCH independent debounced button channels
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NCH           = NCH_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] btn_in,
    output logic [NCH-1:0] btn_level,
    output logic [NCH-1:0] btn_rise,
    output logic [NCH-1:0] btn_fall,
    output logic [NCH-1:0] btn_hold
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_in    (btn_in[i]),
            .btn_level (btn_level[i]),
            .btn_rise  (btn_rise[i]),
            .btn_fall  (btn_fall[i]),
            .btn_hold  (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank
module tb_debounce_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_hold;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [1:0] in;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] hold;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    debounce_bank #(
        .NCH           (2),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (10),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_hold  (btn_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] lv, input logic [1:0] rs,
                           input logic [1:0] fl, input logic [1:0] hd);
        chk({tag, " level"}, btn_level, lv);
        chk({tag, " rise"},  btn_rise,  rs);
        chk({tag, " fall"},  btn_fall,  fl);
        chk({tag, " hold"},  btn_hold,  hd);
    endtask

    initial begin
        // Row r (1-based) is the input before edge r and the outputs after it.
        // ch0 pressed edges 1..20, released from edge 21; ch1 glitches high on edges 8..10.
        for (int r = 1; r <= NVEC; r++) begin
            vecs[r-1].in    = (r <= 7) ? 2'b01 : (r <= 10) ? 2'b11 : (r <= 20) ? 2'b01 : 2'b00;
            vecs[r-1].level = (r >= 6 && r <= 25) ? 2'b01 : 2'b00;
            vecs[r-1].rise  = (r == 6)  ? 2'b01 : 2'b00;
            vecs[r-1].fall  = (r == 26) ? 2'b01 : 2'b00;
            vecs[r-1].hold  = (r >= 16 && r <= 25) ? 2'b01 : 2'b00;
        end

        btn_in = 2'b00;
        rst_n  = 1'b0;
        step();
        step();
        chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        step();

        for (int r = 0; r < NVEC; r++) begin
            btn_in = vecs[r].in;
            step();
            chk_all($sformatf("vec%0d", r + 1), vecs[r].level, vecs[r].rise,
                    vecs[r].fall, vecs[r].hold);
        end

        btn_in = 2'b00;
        repeat (12) step();

        // Bouncy press: 1,0,1,0,1 then held; final rise sampled at k=4, level rises at k=9.
        for (int k = 0; k <= 13; k++) begin
            btn_in = (k >= 4 || (k % 2) == 0) ? 2'b01 : 2'b00;
            step();
            chk($sformatf("bounce%0d level", k), btn_level, (k >= 9) ? 2'b01 : 2'b00);
            chk($sformatf("bounce%0d rise", k),  btn_rise,  (k == 9) ? 2'b01 : 2'b00);
            chk($sformatf("bounce%0d fall", k),  btn_fall,  2'b00);
        end

        btn_in = 2'b00;
        repeat (30) step();
        chk("idle after bounce", btn_level, 2'b00);

        // Both channels rise on the same edge.
        btn_in = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("simul%0d rise", k),  btn_rise,  (k == 6) ? 2'b11 : 2'b00);
            chk($sformatf("simul%0d level", k), btn_level, (k >= 6) ? 2'b11 : 2'b00);
        end

        btn_in = 2'b00;
        repeat (30) step();
        chk("idle after simul", btn_level, 2'b00);

        // Reset two cycles into a press, input held high throughout.
        btn_in = 2'b01;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk_all("mid reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post rst%0d rise", k),  btn_rise,  (k == 6) ? 2'b01 : 2'b00);
            chk($sformatf("post rst%0d level", k), btn_level, (k >= 6) ? 2'b01 : 2'b00);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter NCH, default 2: number of independent button channels, legal 1..16.
REQ-002 Parameter STABLE_CYCLES, default 1000000: consecutive synchronised samples at a new value required before the debounced level changes, legal >= 1.
REQ-003 Parameter HOLD_CYCLES, default 50000000: cycles the debounced level must stay high before the long-press flag asserts, legal >= 1.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser flip-flop depth, legal 2..3.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 btn_in  input  NCH  raw asynchronous button inputs; bit i is channel i.
REQ-008 btn_level  output  NCH  debounced level per channel.
REQ-009 btn_rise  output  NCH  one-cycle pulse on each 0->1 transition of btn_level.
REQ-010 btn_fall  output  NCH  one-cycle pulse on each 1->0 transition of btn_level.
REQ-011 btn_hold  output  NCH  long-press flag per channel.

Function
REQ-012 Each channel shall pass btn_in[i] through a SYNC_STAGES-deep flip-flop chain; only the last stage (sync[i]) feeds the debounce logic.
REQ-013 Each channel shall hold a stable counter, width $clog2(STABLE_CYCLES+1), cleared in any cycle where sync[i] equals btn_level[i].
REQ-014 When sync[i] differs from btn_level[i], the counter shall increment; on the cycle it would reach STABLE_CYCLES, btn_level[i] shall toggle and the counter shall clear.
REQ-015 Latency: a clean input step is reflected on btn_level exactly SYNC_STAGES + STABLE_CYCLES clock edges after the first edge sampling the new value.
REQ-016 A deviation lasting fewer than STABLE_CYCLES synchronised samples shall leave btn_level, btn_rise, btn_fall and btn_hold unchanged.
REQ-017 STABLE_CYCLES = 1 shall make btn_level follow sync[i] with one cycle of delay.
REQ-018 btn_rise[i] / btn_fall[i] shall be registered and assert in the same cycle btn_level[i] takes its new value, for exactly one cycle; never both in the same cycle.
REQ-019 Each channel shall hold a hold counter, width $clog2(HOLD_CYCLES+1), incrementing while btn_level[i] = 1, saturating at HOLD_CYCLES, cleared while btn_level[i] = 0.
REQ-020 btn_hold[i] shall assert in the cycle the hold counter reaches HOLD_CYCLES and stay asserted until the cycle btn_level[i] goes 0, in which it deasserts together with the btn_fall pulse.
REQ-021 Channels shall be fully independent; simultaneous transitions on several channels shall each produce their own pulses in the same cycle.
REQ-022 All outputs shall be registered; no combinational path from btn_in to any output.

Reset
REQ-023 While rst_n = 0 at a clock edge, synchroniser stages, both counters, btn_level, btn_rise, btn_fall and btn_hold shall all become 0.
REQ-024 Reset asserted mid-count shall discard partial counts; a stale pulse shall not appear after release.
REQ-025 An input held high through reset shall, after release, produce btn_level = 1 and one btn_rise pulse after the full REQ-015 latency.

Structure
REQ-026 Default parameter values and legal ranges shall live in shared package debounce_pkg.
REQ-027 Per-channel logic shall be sub-module debounce_chan (sync, stable counter, hold counter, pulse registers), instantiated NCH times by a generate loop in debounce_bank.
REQ-028 Counter widths shall be derived localparams inside debounce_chan, not ports.

Verification (NCH=2, STABLE_CYCLES=4, HOLD_CYCLES=10, SYNC_STAGES=2, 10 ns clock)
REQ-029 Clean press: btn_in[0] 0->1 held -> btn_level[0]=1 and btn_rise[0] one-cycle pulse exactly 6 edges later; channel 1 outputs stay 0.
REQ-030 Glitch rejection: btn_in[1] high for 30 ns (3 cycles) then low -> btn_level[1], btn_rise[1] stay 0 throughout.
REQ-031 Bouncy press: btn_in[0] toggles 1,0,1,0,1 at 10 ns intervals then stays 1 -> single btn_rise[0] pulse 6 edges after the final rise, no btn_fall.
REQ-032 Long press: btn_in[0] held 200 ns -> btn_hold[0] asserts 10 cycles after btn_level[0] rises; on release btn_hold[0] and btn_level[0] drop in the same cycle btn_fall[0] pulses.
REQ-033 Simultaneous: both inputs rise on the same edge -> btn_rise = 2'b11 for one cycle, 6 edges later.
REQ-034 Reset mid-count: rst_n low for one edge 2 cycles into a press, input held high -> all outputs 0 that cycle, then btn_rise[0] pulses 6 edges after rst_n returns high.
